// File: rtl/product_accumulator.sv
// Sums CNT unsigned 8-bit products into an ACC_W-bit result with a sticky wrap flag,
// then holds the result with a valid/ready handshake before collecting the next batch.
module product_accumulator #(
  parameter int unsigned CNT   = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pro,
  input  logic             pro_valid,
  output logic             pro_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(CNT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CNT - 1);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic               flag_next;

  assign accept    = (state_q == StAcc) && pro_valid;
  // One extra bit catches the carry out of the accumulator MSB.
  assign sum_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, pro};
  assign flag_next = flag_q | sum_ext[ACC_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StAcc: begin
        if (accept) begin
          acc_d  = sum_ext[ACC_W-1:0];
          cnt_d  = cnt_q + CntW'(1);
          flag_d = flag_next;
          if (cnt_q == CntLast) begin
            state_d = StHold;
            sum_d   = sum_ext[ACC_W-1:0];
            ovf_d   = flag_next;
          end
        end
      end
      StHold: begin
        if (sum_ready) begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
          flag_d  = 1'b0;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pro_ready = (state_q == StAcc);
  assign sum_valid = (state_q == StHold);
  assign sum_out   = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL be parameterised as follows, one per line: name, default, meaning.
- CNT, 4, number of products summed per result; legal range 1..255.
- ACC_W, 12, accumulator and result width in bits; legal range 8..32.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, the single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- pro, input, 8, unsigned product from the upstream 4x4 multiplier.
- pro_valid, input, 1, pro carries a valid product this cycle.
- pro_ready, output, 1, block can accept a product this cycle.
- sum_out, output, ACC_W, accumulated result of CNT products.
- sum_valid, output, 1, sum_out and ovf are valid.
- sum_ready, input, 1, downstream consumes the result this cycle.
- ovf, output, 1, the result exceeded 2^ACC_W-1 and was wrapped.

REQ-003 The block SHALL have one clock domain (clk) and a synchronous, active-high reset (rst); there SHALL be no other clocks and no asynchronous logic.

Function
REQ-004 The block SHALL use a two-state machine: ACC (collecting products) and HOLD (presenting a result).
REQ-005 In ACC, pro_ready SHALL be 1 and sum_valid SHALL be 0; in HOLD, pro_ready SHALL be 0 and sum_valid SHALL be 1.
REQ-006 A product SHALL be accepted only on a rising edge where pro_valid=1 and pro_ready=1.
REQ-007 On each accepted product, acc SHALL become (acc + zero-extended pro) mod 2^ACC_W, and the sample counter SHALL increment.
REQ-008 An accept that produces a carry out of bit ACC_W-1 SHALL set the internal overflow flag; once set, the flag SHALL stay set until the result is consumed.
REQ-009 A cycle with pro_valid=0 in ACC SHALL leave acc, counter and flag unchanged; gaps of any length SHALL be allowed.
REQ-010 The accept that brings the count to CNT SHALL move the machine to HOLD on the same edge.
- On that edge, sum_out SHALL load the final sum, including that last product.
- On that edge, ovf SHALL load the final overflow flag.
- Latency: sum_valid SHALL be 1 in the cycle immediately after the last accept.
REQ-011 While in HOLD, sum_out and ovf SHALL remain stable, and pro values SHALL be ignored whatever pro_valid is.
REQ-012 In HOLD, an edge with sum_ready=1 SHALL return the machine to ACC and clear acc, counter and the overflow flag to 0.
- sum_out and ovf SHALL keep their last values until the next result loads.
- pro_ready SHALL be 1 in the following cycle, giving exactly one bubble between results.
REQ-013 A sum_ready pulse while in ACC SHALL have no effect.
REQ-014 With CNT=1, every accepted product SHALL move the machine straight to HOLD, with sum_out = pro.
REQ-015 The counter SHALL be ceil(log2(CNT+1)) bits wide and SHALL never exceed CNT.

Reset
REQ-016 On a rising edge with rst=1, the block SHALL enter ACC and clear acc, counter, overflow flag, sum_out and ovf to 0.
- After that edge: pro_ready=1 and sum_valid=0.
REQ-017 rst SHALL take priority over every other input, including a simultaneous accept or sum_ready.
REQ-018 A reset asserted mid-accumulation or in HOLD SHALL discard the partial or pending result; no sum_valid SHALL follow from pre-reset products.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Basic sum (CNT=4, ACC_W=12): products 0x00, 0x0D, 0x0A, 0x15 on consecutive cycles, sum_ready=1 -> sum_valid=1 one cycle after the 4th accept, sum_out=0x02C, ovf=0, pro_ready=1 again two cycles later.
- Gaps (CNT=4): same products with pro_valid low for 3 cycles between each -> sum_out=0x02C; acc does not change on idle cycles.
- Overflow (CNT=4, ACC_W=8): products 0x80, 0x80, 0x01, 0x01 -> sum_out=0x02, ovf=1; the next result 0x01 x4 -> sum_out=0x04, ovf=0.
- Backpressure: sum_ready held low for 5 cycles in HOLD while pro_valid=1 with pro=0xFF -> sum_out stable, pro_ready=0 throughout, no product absorbed; after sum_ready=1 the next result excludes those values.
- Reset mid-operation: rst pulsed after 2 of 4 accepts (0xE1, 0x9A), then 4 products of 0x01 -> sum_out=0x004, ovf=0.
- CNT=1: pro=0xC3 accepted -> next cycle sum_out=0x0C3, sum_valid=1.
